// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR stream cipher (encrypter and decrypter).
// Provides the LFSR width, default seed, tap equation and sync state encoding.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h41;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } sync_state_t;

  // Shift left, feedback from taps 7,6,5,0. Must match the encrypter bit-for-bit.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[6:0], q[0] ^ q[5] ^ q[6] ^ q[7]};
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Keystream generator: LFSR register plus the seed it restarts from.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load, load_val   load a new seed (zero is replaced by RESET_SEED)
//   step             advance the LFSR by one state
//   rewind           restart the LFSR from the stored seed
//   key              current keystream byte (LFSR contents)
// Priority: load > rewind > step.
module lfsr_keystream
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  input  logic              rewind,
  output logic [LFSR_W-1:0] key
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] eff_seed;

  // An all-zero LFSR would stick at zero forever, so never load one.
  assign eff_seed = (load_val == '0) ? RESET_SEED : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= RESET_SEED;
      seed_reg <= RESET_SEED;
    end else if (load) begin
      lfsr     <= eff_seed;
      seed_reg <= eff_seed;
    end else if (rewind) begin
      lfsr <= seed_reg;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign key = lfsr;

endmodule

// File: rtl/lfsr_stream_decrypter.sv
// Receive-side LFSR stream decrypter. Ciphertext bytes are XORed with a local
// keystream; when SYNC_EN is set the first decrypted byte must equal SYNC_BYTE
// before any plaintext is emitted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   seed_load, seed_val   load a new seed and restart sync (highest priority)
//   in_valid/in_ready/in_data     ciphertext input handshake
//   out_valid/out_ready/out_data  registered plaintext output handshake
//   locked                1 while in RUN
//   sync_err              sticky header mismatch flag
//   byte_cnt              saturating count of plaintext bytes emitted
module lfsr_stream_decrypter
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED,
  parameter logic [LFSR_W-1:0] SYNC_BYTE  = 8'hA5,
  parameter bit                SYNC_EN    = 1'b1,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LFSR_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] out_data,
  output logic              locked,
  output logic              sync_err,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam sync_state_t INIT_STATE = SYNC_EN ? HUNT : RUN;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  sync_state_t       state_q, state_d;
  logic [LFSR_W-1:0] key_p0;
  logic [LFSR_W-1:0] plain_p0;
  logic              accept;
  logic              hdr_ok;
  logic              ks_step;
  logic              ks_rewind;

  // In HUNT nothing is emitted, so input never waits on the output register.
  assign in_ready = !seed_load && ((state_q == HUNT) || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign plain_p0 = in_data ^ key_p0;
  assign hdr_ok   = (plain_p0 == SYNC_BYTE);

  assign ks_step   = accept && ((state_q == RUN) || hdr_ok);
  assign ks_rewind = accept && (state_q == HUNT) && !hdr_ok;

  lfsr_keystream #(
    .RESET_SEED(RESET_SEED)
  ) u_keystream (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seed_load),
    .load_val(seed_val),
    .step    (ks_step),
    .rewind  (ks_rewind),
    .key     (key_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = INIT_STATE;
    end else if (accept && (state_q == HUNT) && hdr_ok) begin
      state_d = RUN;
    end
  end

  assign locked = (state_q == RUN);

  // ---- p0 -> output register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sync_err  <= 1'b0;
      byte_cnt  <= '0;
    end else if (seed_load) begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      if (accept && (state_q == RUN)) begin
        out_valid <= 1'b1;
        out_data  <= plain_p0;
        byte_cnt  <= sat_inc(byte_cnt);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ks_rewind) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_decrypter.sv
module tb_lfsr_stream_decrypter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [7:0]  seed_val;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        locked;
  logic        sync_err;
  logic [15:0] byte_cnt;

  always #5 clk = ~clk;

  lfsr_stream_decrypter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .locked   (locked),
    .sync_err (sync_err),
    .byte_cnt (byte_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int flush_gen = 0;

  // Reference model: keystream position counted from the active seed.
  logic [7:0] m_seed;
  int         m_pos;
  bit         m_locked;
  bit         m_err;
  int         m_cnt;
  logic [7:0] enc_lfsr;

  function automatic logic [7:0] step8(input logic [7:0] q);
    return {q[6:0], q[0] ^ q[5] ^ q[6] ^ q[7]};
  endfunction

  function automatic logic [7:0] key_at(input logic [7:0] s, input int k);
    logic [7:0] q;
    q = s;
    for (int i = 0; i < k; i++) q = step8(q);
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [7:0] s);
    m_seed = s; m_pos = 0; m_locked = 0; m_err = 0; m_cnt = 0;
    sb.delete();
    flush_gen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic [7:0] p;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #2;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk); #2; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    p = b ^ key_at(m_seed, m_pos);
    if (!m_locked) begin
      if (p == 8'hA5) begin m_locked = 1; m_pos++; end
      else begin m_err = 1; m_pos = 0; end
    end else begin
      m_pos++;
      sb.push_back(p);
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
    check({tag, "_sync_err"}, {31'd0, sync_err}, {31'd0, m_err});
    check({tag, "_byte_cnt"}, {16'd0, byte_cnt}, m_cnt);
  endtask

  task automatic seed_load_op(input logic [7:0] v);
    @(negedge clk);
    seed_load = 1'b1;
    seed_val  = v;
    #2;
    check("seed_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    model_reset((v == 8'h00) ? 8'h41 : v);
    #1;
    seed_load = 1'b0;
    in_valid  = 1'b0;
    check("seed_out_valid", {31'd0, out_valid}, 32'd0);
    check_state("seed");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic enc_start(input logic [7:0] s);
    enc_lfsr = (s == 8'h00) ? 8'h41 : s;
  endtask

  task automatic enc_send(input logic [7:0] p);
    logic [7:0] c;
    c = p ^ enc_lfsr;
    enc_lfsr = step8(enc_lfsr);
    send_byte(c);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset(8'h41);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    time t0;
    bit  held;
    logic [7:0] held_data;
    logic [7:0] exp_b;
    int  gen_seen;
    bit  r;

    rst_n = 1'b0; seed_load = 1'b0; seed_val = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    rst_n = 1'b1;
    model_reset(8'h41);
    held = 0; held_data = 8'h00; gen_seen = flush_gen;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (held && gen_seen == flush_gen) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {24'd0, out_data}, {24'd0, held_data});
          end
          gen_seen = flush_gen;
          r = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
          out_ready = r;
          held = out_valid && !r;
          held_data = out_data;
          if (out_valid && r) begin
            if (sb.size() == 0) begin
              check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
              exp_b = sb.pop_front();
              check("out_data", {24'd0, out_data}, {24'd0, exp_b});
            end
          end
        end
      end
      begin : driver
        // Lock on E4, then first data byte CA -> 48
        send_byte(8'hE4);
        check_state("t1_lock");
        check("t1_no_out", {31'd0, out_valid}, 32'd0);
        send_byte(8'hCA);
        check_state("t1_data");
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_data", {24'd0, out_data}, 32'h48);
        idle();
        wait_drain();

        // Header mismatch, then relock from the rewound seed
        pulse_reset();
        send_byte(8'h00);
        check_state("t3_err");
        send_byte(8'hE4);
        check_state("t3_lock");
        send_byte(8'hCA);
        idle();
        wait_drain();

        // Back-pressure stall then full throughput
        ready_mode = 1;
        send_byte(8'h5A);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int i = 0; i < 5; i++) begin
          #2;
          check("t2_stall_in_ready", {31'd0, in_ready}, 32'd0);
          @(negedge clk);
        end
        ready_mode = 0;
        @(posedge clk);
        t0 = $time;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        check("t2_throughput_cycles", 32'(($time - t0) / 10), 32'd6);
        idle();
        wait_drain();
        check_state("t2_end");

        // Zero seed load falls back to the default seed
        seed_load_op(8'h00);
        enc_start(8'h00);
        enc_send(8'hA5);
        check_state("t4_lock");
        for (int i = 0; i < 4; i++) enc_send(8'($urandom));
        idle();
        wait_drain();

        // Seed load drops a pending output and consumes nothing
        seed_load_op(8'h3C);
        enc_start(8'h3C);
        enc_send(8'hA5);
        ready_mode = 1;
        enc_send(8'h77);
        in_valid = 1'b1;
        in_data  = 8'h99;
        seed_load_op(8'h9D);
        ready_mode = 0;
        enc_start(8'h9D);
        enc_send(8'hA5);
        check_state("t5_lock");
        for (int i = 0; i < 4; i++) enc_send(8'($urandom));
        idle();
        wait_drain();

        // Asynchronous reset between edges mid-stream
        ready_mode = 2;
        enc_start(8'h41);
        enc_send(8'hA5);
        for (int i = 0; i < 8; i++) enc_send(8'($urandom));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset(8'h41);
        in_valid = 1'b0;
        #1;
        check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_out_data", {24'd0, out_data}, 32'd0);
        check("t6_rst_locked", {31'd0, locked}, 32'd0);
        check("t6_rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("t6_rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized loopback with random seeds and back-pressure
        for (int s = 0; s < 3; s++) begin
          seed_val = 8'($urandom);
          seed_load_op(seed_val);
          enc_start(seed_val);
          enc_send(8'hA5);
          for (int i = 0; i < 30; i++) begin
            enc_send(8'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
          end
          idle();
          wait_drain();
          check_state("loop_seg");
        end
        seed_val = 8'($urandom);
        seed_load_op(seed_val);
        enc_start(seed_val);
        enc_send(8'hA5);
        for (int i = 0; i < 1000; i++) begin
          enc_send(8'($urandom));
          if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        wait_drain();
        check("loop_byte_cnt", {16'd0, byte_cnt}, 32'd1000);
        check_state("loop_end");
      end
    join_any
    disable fork;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_decrypter.md
Name: lfsr_stream_decrypter

Overview:
- Receive-side counterpart of the 8-bit LFSR stream encrypter.
- Accepts ciphertext bytes over a valid/ready handshake and XORs each byte with a locally generated keystream.
- The keystream uses the same polynomial and seed as the encrypter.
- Locks to the sender by checking a known sync header, then emits plaintext bytes over a registered valid/ready output.

Parameters:
- RESET_SEED, 8'h41: LFSR value after reset. Also substituted whenever an all-zero seed is loaded.
- SYNC_BYTE, 8'hA5: plaintext value the first decrypted byte must match to achieve lock.
- SYNC_EN, 1: 1 = hunt for SYNC_BYTE before emitting data; 0 = emit from the first byte.
- CNT_W, 16: width of the saturating plaintext byte counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  one-cycle strobe: load seed_val and restart sync.
- seed_val  in  8  new seed, sampled when seed_load=1.
- in_valid  in  1  ciphertext byte present.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  8  ciphertext byte.
- out_valid  out  1  plaintext byte present on out_data.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  8  plaintext byte (registered).
- locked  out  1  1 while in RUN state.
- sync_err  out  1  sticky: a header mismatch has occurred since the last reset or seed_load.
- byte_cnt  out  CNT_W  plaintext bytes emitted; saturates at all-ones.

Behaviour:
- The clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - lfsr = RESET_SEED; seed_reg = RESET_SEED.
  - state = HUNT if SYNC_EN, else RUN.
  - out_valid = 0, out_data = 0, sync_err = 0, byte_cnt = 0.
  - locked = !SYNC_EN.
- LFSR step: next = {lfsr[6:0], lfsr[0]^lfsr[5]^lfsr[6]^lfsr[7]}. Identical to the encrypter.
- Keystream advance:
  - The LFSR steps once per accepted input byte (in_valid && in_ready) and never otherwise.
  - plain = in_data ^ lfsr, using the pre-step value.
- in_ready:
  - 0 whenever seed_load=1.
  - HUNT: 1.
  - RUN: !out_valid || out_ready. This gives full throughput of one byte per cycle.
- HUNT, on accept:
  - plain == SYNC_BYTE: go to RUN, locked=1, LFSR steps, nothing emitted.
  - Mismatch: sync_err=1 (sticky), lfsr reloads seed_reg, stay in HUNT, nothing emitted.
- RUN, on accept:
  - out_data <= plain; out_valid <= 1 on the next edge. Input-to-output latency is 1 cycle.
  - byte_cnt += 1, saturating.
- Output register:
  - out_valid/out_data hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready with no simultaneous accept.
  - Simultaneous pop and accept: out_valid stays 1 and out_data is replaced.
- seed_load has highest priority, above any handshake:
  - Effective seed = (seed_val==0 ? RESET_SEED : seed_val); all-zero would lock up the LFSR.
  - lfsr <= effective seed; seed_reg <= effective seed.
  - state <= HUNT/RUN per SYNC_EN; locked is updated to match.
  - out_valid <= 0: a pending output byte is dropped.
  - sync_err <= 0; byte_cnt <= 0.
  - in_ready=0 that cycle, so no byte is consumed.
- Reset asserted mid-transfer: all state returns to reset values immediately; pending output is lost.
- The LFSR never holds 0: its reachable states exclude zero and every load is guarded.

Decomposition:
- Shared package lfsr_pkg, used by both encrypter and decrypter:
  - LFSR_W = 8.
  - DEFAULT_SEED = 8'h41.
  - Function lfsr_next(q) implementing the tap equation.
  - State enum {HUNT, RUN}.
- Sub-module lfsr_keystream:
  - Holds the LFSR register and seed_reg.
  - Inputs: load, load_val, step, rewind.
  - Output: key.
  - Reusable by the encrypter.
- The FSM, handshake, output register and counter live in the top block.

Test Plan:
1. Reset (SYNC_EN=1); send E4 (A5^41) -> locked=1, sync_err=0, no out_valid, LFSR=82. Send CA (48^82) -> next cycle out_valid=1, out_data=48, byte_cnt=1, LFSR=05.
2. Lock, then hold out_ready=0 while streaming -> after one byte in_ready=0, out_data stable for 5 cycles, LFSR not stepping. Release out_ready -> back-to-back bytes at 1/cycle, plaintext matches a software model.
3. After reset send 00 -> plain 41≠A5, sync_err=1, locked=0, LFSR=41. Then send E4 -> locked=1, sync_err stays 1.
4. seed_load with seed_val=00 -> LFSR=41 (not 0), state HUNT, byte_cnt=0, sync_err=0. Then E4 locks.
5. seed_load asserted the same cycle as in_valid while out_valid=1 pending -> in_ready=0, byte not consumed, out_valid=0 next cycle, LFSR=seed.
6. Assert rst_n low asynchronously mid-stream between clock edges -> outputs at reset values before the next edge. Plus randomized encrypter-to-decrypter loopback of 1000 bytes with random seeds and back-pressure -> plaintext exact and byte_cnt=1000.
